act_streamer: RTL and testbench

ACT_STREAMER -- requirements
Module: act_streamer

---
 rtl/act_streamer_if.sv | 36 +++
 rtl/act_streamer.sv | 129 ++++++++++++
 tb/tb_act_streamer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/act_streamer_if.sv
// Streamer bus: pixel memory read port, convolver feed and frame control.
// The streamer drives the master modport; the memory/convolver/host side uses slave.
interface act_streamer_if #(
   parameter int AW = 9
);
   logic          start;
   logic          pause;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [15:0]   mem_rdata;
   logic [15:0]   activation;
   logic          ce;
   logic          conv_rst;
   logic          end_conv;
   logic          busy;
   logic          done;
`ifdef ACT_STREAMER_WATCHDOG_EN
   logic          err;
`endif

   modport master (
      input  start, pause, mem_rdata, end_conv,
      output mem_addr, mem_rd_en, activation, ce, conv_rst, busy, done
`ifdef ACT_STREAMER_WATCHDOG_EN
      , output err
`endif
   );

   modport slave (
      output start, pause, mem_rdata, end_conv,
      input  mem_addr, mem_rd_en, activation, ce, conv_rst, busy, done
`ifdef ACT_STREAMER_WATCHDOG_EN
      , input err
`endif
   );
endinterface

// File: rtl/act_streamer.sv
// Streams an N x N frame from pixel memory to the convolver (read-to-ce latency 2, pause stalls reads/drain).
// Optional ACT_STREAMER_WATCHDOG_EN: DRAIN gives up after 8 pulses without end_conv and flags err.
module act_streamer #(
   parameter int N  = 10,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          global_rst,
   act_streamer_if.master bus
);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic          conv_rst_q;
   logic          busy_q;
   logic          done_q;
   logic          rd_d1;
   logic          ce_q;
   logic [15:0]   act_q;
   logic          rd_en;
   logic          pipe_empty;
   logic          drain_ce;
`ifdef ACT_STREAMER_WATCHDOG_EN
   logic [3:0]    wd_cnt;
   logic          err_q;
`endif

   assign rd_en      = (state == STREAM) && !bus.pause;
   assign pipe_empty = !rd_d1 && !ce_q;
   // Drain pulses are combinational so end_conv suppresses ce in the very cycle it is seen.
   assign drain_ce   = (state == DRAIN) && !bus.pause && pipe_empty && !bus.end_conv;

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         conv_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef ACT_STREAMER_WATCHDOG_EN
         wd_cnt     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         conv_rst_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef ACT_STREAMER_WATCHDOG_EN
         err_q      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= PRIME;
                  conv_rst_q <= 1'b1;
                  busy_q     <= 1'b1;
                  addr_q     <= '0;
               end
            end
            PRIME: state <= STREAM;
            STREAM: begin
               if (rd_en) begin
                  if (addr_q == LAST_ADDR) begin
                     state  <= DRAIN;
                     addr_q <= '0;
`ifdef ACT_STREAMER_WATCHDOG_EN
                     wd_cnt <= '0;
`endif
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (bus.end_conv) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
`ifdef ACT_STREAMER_WATCHDOG_EN
               else if (drain_ce) begin
                  if (wd_cnt == 4'd7) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
`endif
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Fixed two-stage read pipeline; act_q is zeroed by drain pulses so it holds 0 afterwards.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         rd_d1 <= 1'b0;
         ce_q  <= 1'b0;
         act_q <= '0;
      end else begin
         rd_d1 <= rd_en;
         ce_q  <= rd_d1;
         if (rd_d1) begin
            act_q <= bus.mem_rdata;
         end else if (drain_ce) begin
            act_q <= '0;
         end
      end
   end

   assign bus.mem_addr   = addr_q;
   assign bus.mem_rd_en  = rd_en;
   assign bus.ce         = ce_q | drain_ce;
   assign bus.activation = drain_ce ? 16'h0000 : act_q;
   assign bus.conv_rst   = conv_rst_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
`ifdef ACT_STREAMER_WATCHDOG_EN
   assign bus.err        = err_q;
`endif
endmodule

// File: tb/tb_act_streamer.sv
// Directed bench for act_streamer: cycle 0 of each frame is the cycle start is driven high.
// Memory model returns mem[a] = a one cycle after each read strobe.
module tb_act_streamer;
   logic clk;
   logic global_rst;
   int   total;
   int   bad;

   act_streamer_if #(.AW(9)) bus ();

   act_streamer #(.N(10), .AW(9)) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= 16'(bus.mem_addr);
   end

   logic        r_rd   [256];
   logic [8:0]  r_addr [256];
   logic        r_ce   [256];
   logic [15:0] r_act  [256];
   logic        r_cr   [256];
   logic        r_done [256];
   logic        r_busy [256];
   logic        r_err  [256];

   // Drives one frame's inputs cycle by cycle and records outputs mid-cycle.
   task automatic run_frame(input int ncyc, input int p_lo, input int p_hi,
                            input int ec1, input int ec2, input bit hold_start);
      for (int c = 0; c < ncyc; c++) begin
         bus.start    = hold_start ? 1'b1 : (c == 0);
         bus.pause    = (c >= p_lo && c <= p_hi);
         bus.end_conv = (c == ec1) || (c == ec2);
         @(negedge clk);
         r_rd[c]   = bus.mem_rd_en;
         r_addr[c] = bus.mem_addr;
         r_ce[c]   = bus.ce;
         r_act[c]  = bus.activation;
         r_cr[c]   = bus.conv_rst;
         r_done[c] = bus.done;
         r_busy[c] = bus.busy;
`ifdef ACT_STREAMER_WATCHDOG_EN
         r_err[c]  = bus.err;
`else
         r_err[c]  = 1'b0;
`endif
         @(posedge clk);
         #1;
      end
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      bus.end_conv = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 global_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      global_rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total += 7;
      if (bus.mem_addr !== 9'd0)       begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.mem_addr); end
      if (bus.mem_rd_en !== 1'b0)      begin bad++; $display("FAIL reset_rd_en got=%0b exp=0", bus.mem_rd_en); end
      if (bus.activation !== 16'd0)    begin bad++; $display("FAIL reset_act got=%0d exp=0", bus.activation); end
      if (bus.ce !== 1'b0)             begin bad++; $display("FAIL reset_ce got=%0b exp=0", bus.ce); end
      if (bus.conv_rst !== 1'b0)       begin bad++; $display("FAIL reset_conv_rst got=%0b exp=0", bus.conv_rst); end
      if (bus.busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      if (bus.done !== 1'b0)           begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
      @(negedge clk);
      global_rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      run_frame(110, -1, -1, 106, -1, 1'b0);
      for (int c = 0; c < 110; c++) begin
         bit e_rd, e_ce;
         e_rd = (c >= 2 && c <= 101);
         e_ce = (c >= 4 && c <= 105);
         total += 5;
         if (r_rd[c] !== e_rd) begin bad++; $display("FAIL basic_rd c=%0d got=%0b exp=%0b", c, r_rd[c], e_rd); end
         if (r_ce[c] !== e_ce) begin bad++; $display("FAIL basic_ce c=%0d got=%0b exp=%0b", c, r_ce[c], e_ce); end
         if (r_cr[c] !== (c == 1)) begin bad++; $display("FAIL basic_conv_rst c=%0d got=%0b", c, r_cr[c]); end
         if (r_done[c] !== (c == 107)) begin bad++; $display("FAIL basic_done c=%0d got=%0b", c, r_done[c]); end
         if (r_busy[c] !== (c >= 1 && c <= 107)) begin bad++; $display("FAIL basic_busy c=%0d got=%0b", c, r_busy[c]); end
         if (e_rd) begin
            total++;
            if (r_addr[c] !== 9'(c - 2)) begin bad++; $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, r_addr[c], c - 2); end
         end
         if (e_ce) begin
            total++;
            if (r_act[c] !== ((c <= 103) ? 16'(c - 4) : 16'd0))
               begin bad++; $display("FAIL basic_act c=%0d got=%0d", c, r_act[c]); end
         end
      end
      // ce low after the drain pulses: activation must stay at 0
      total++;
      if (r_act[106] !== 16'd0) begin bad++; $display("FAIL basic_act_hold got=%0d exp=0", r_act[106]); end
   endtask

   task automatic test_pause();
      int k;
      run_frame(116, 10, 14, 111, -1, 1'b0);
      for (int c = 0; c < 116; c++) begin
         bit e_rd, e_ce;
         e_rd = (c >= 2 && c <= 9) || (c >= 15 && c <= 106);
         e_ce = (c >= 4 && c <= 11) || (c >= 17 && c <= 110);
         total += 3;
         if (r_rd[c] !== e_rd) begin bad++; $display("FAIL pause_rd c=%0d got=%0b exp=%0b", c, r_rd[c], e_rd); end
         if (r_ce[c] !== e_ce) begin bad++; $display("FAIL pause_ce c=%0d got=%0b exp=%0b", c, r_ce[c], e_ce); end
         if (r_done[c] !== (c == 112)) begin bad++; $display("FAIL pause_done c=%0d got=%0b", c, r_done[c]); end
         if (e_rd) begin
            total++;
            if (r_addr[c] !== ((c <= 9) ? 9'(c - 2) : 9'(c - 7)))
               begin bad++; $display("FAIL pause_addr c=%0d got=%0d", c, r_addr[c]); end
         end
      end
      // Reads of addresses 6 and 7 were in flight when pause rose
      total += 2;
      if (r_act[10] !== 16'd6) begin bad++; $display("FAIL pause_inflight0 got=%0d exp=6", r_act[10]); end
      if (r_act[11] !== 16'd7) begin bad++; $display("FAIL pause_inflight1 got=%0d exp=7", r_act[11]); end
      k = 0;
      for (int c = 0; c <= 108; c++) begin
         if (r_ce[c] === 1'b1) begin
            total++;
            if (r_act[c] !== 16'(k)) begin bad++; $display("FAIL pause_order idx=%0d got=%0d exp=%0d", k, r_act[c], k); end
            k++;
         end
      end
      total++;
      if (k !== 100) begin bad++; $display("FAIL pause_count got=%0d exp=100", k); end
   endtask

   task automatic test_start_held();
      run_frame(220, -1, -1, 106, 214, 1'b1);
      for (int c = 0; c < 220; c++) begin
         total += 2;
         if (r_cr[c] !== (c == 1 || c == 109 || c == 217))
            begin bad++; $display("FAIL held_conv_rst c=%0d got=%0b", c, r_cr[c]); end
         if (r_done[c] !== (c == 107 || c == 215))
            begin bad++; $display("FAIL held_done c=%0d got=%0b", c, r_done[c]); end
      end
      total += 3;
      if (r_rd[109] !== 1'b0) begin bad++; $display("FAIL held_rd_prime got=%0b exp=0", r_rd[109]); end
      if (r_rd[110] !== 1'b1) begin bad++; $display("FAIL held_rd_first got=%0b exp=1", r_rd[110]); end
      if (r_addr[110] !== 9'd0) begin bad++; $display("FAIL held_addr_first got=%0d exp=0", r_addr[110]); end
      pulse_reset();
   endtask

   task automatic test_reset_mid();
      run_frame(39, -1, -1, -1, -1, 1'b0);
      total += 2;
      if (bus.mem_addr !== 9'd37) begin bad++; $display("FAIL mid_addr got=%0d exp=37", bus.mem_addr); end
      if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL mid_rd_en got=%0b exp=1", bus.mem_rd_en); end
      #2 global_rst = 1'b1;
      #1;
      total += 7;
      if (bus.mem_addr !== 9'd0)    begin bad++; $display("FAIL mid_rst_addr got=%0d exp=0", bus.mem_addr); end
      if (bus.mem_rd_en !== 1'b0)   begin bad++; $display("FAIL mid_rst_rd_en got=%0b exp=0", bus.mem_rd_en); end
      if (bus.activation !== 16'd0) begin bad++; $display("FAIL mid_rst_act got=%0d exp=0", bus.activation); end
      if (bus.ce !== 1'b0)          begin bad++; $display("FAIL mid_rst_ce got=%0b exp=0", bus.ce); end
      if (bus.conv_rst !== 1'b0)    begin bad++; $display("FAIL mid_rst_conv_rst got=%0b exp=0", bus.conv_rst); end
      if (bus.busy !== 1'b0)        begin bad++; $display("FAIL mid_rst_busy got=%0b exp=0", bus.busy); end
      if (bus.done !== 1'b0)        begin bad++; $display("FAIL mid_rst_done got=%0b exp=0", bus.done); end
      @(posedge clk);
      @(negedge clk);
      global_rst = 1'b0;
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%0b exp=0", bus.done); end
      @(posedge clk);
      #1;
      run_frame(110, -1, -1, 106, -1, 1'b0);
      total += 6;
      if (r_rd[1] !== 1'b0)    begin bad++; $display("FAIL restart_rd1 got=%0b exp=0", r_rd[1]); end
      if (r_rd[2] !== 1'b1)    begin bad++; $display("FAIL restart_rd2 got=%0b exp=1", r_rd[2]); end
      if (r_addr[2] !== 9'd0)  begin bad++; $display("FAIL restart_addr got=%0d exp=0", r_addr[2]); end
      if (r_ce[4] !== 1'b1)    begin bad++; $display("FAIL restart_ce got=%0b exp=1", r_ce[4]); end
      if (r_act[4] !== 16'd0)  begin bad++; $display("FAIL restart_act got=%0d exp=0", r_act[4]); end
      if (r_done[107] !== 1'b1) begin bad++; $display("FAIL restart_done got=%0b exp=1", r_done[107]); end
   endtask

`ifdef ACT_STREAMER_WATCHDOG_EN
   task automatic test_watchdog();
      run_frame(115, -1, -1, -1, -1, 1'b0);
      for (int c = 100; c < 115; c++) begin
         bit e_ce;
         e_ce = (c >= 100 && c <= 111);
         total += 3;
         if (r_ce[c] !== e_ce) begin bad++; $display("FAIL wd_ce c=%0d got=%0b exp=%0b", c, r_ce[c], e_ce); end
         if (r_done[c] !== (c == 112)) begin bad++; $display("FAIL wd_done c=%0d got=%0b", c, r_done[c]); end
         if (r_err[c] !== (c == 112)) begin bad++; $display("FAIL wd_err c=%0d got=%0b", c, r_err[c]); end
         if (c >= 104 && c <= 111) begin
            total++;
            if (r_act[c] !== 16'd0) begin bad++; $display("FAIL wd_act c=%0d got=%0d exp=0", c, r_act[c]); end
         end
      end
      total++;
      if (r_busy[113] !== 1'b0) begin bad++; $display("FAIL wd_idle got=%0b exp=0", r_busy[113]); end
   endtask
`else
   task automatic test_no_watchdog();
      run_frame(140, -1, -1, -1, -1, 1'b0);
      for (int c = 104; c < 140; c++) begin
         total += 3;
         if (r_ce[c] !== 1'b1) begin bad++; $display("FAIL nowd_ce c=%0d got=%0b exp=1", c, r_ce[c]); end
         if (r_act[c] !== 16'd0) begin bad++; $display("FAIL nowd_act c=%0d got=%0d exp=0", c, r_act[c]); end
         if (r_done[c] !== 1'b0) begin bad++; $display("FAIL nowd_done c=%0d got=%0b exp=0", c, r_done[c]); end
      end
      total++;
      if (r_busy[139] !== 1'b1) begin bad++; $display("FAIL nowd_busy got=%0b exp=1", r_busy[139]); end
      pulse_reset();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

   initial begin
      clk          = 1'b0;
      global_rst   = 1'b1;
      total        = 0;
      bad          = 0;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      bus.end_conv = 1'b0;
      bus.mem_rdata = 16'd0;
      test_reset();
      test_basic();
      test_pause();
      test_start_held();
      test_reset_mid();
`ifdef ACT_STREAMER_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
